// File: rtl/warp_pkg.sv
// Shared definitions for the warp scheduler: core pipeline state encoding and scheduler FSM states.
package warp_pkg;

  localparam logic [2:0] CoreIdle    = 3'b000;
  localparam logic [2:0] CoreFetch   = 3'b001;
  localparam logic [2:0] CoreDecode  = 3'b010;
  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreWait    = 3'b100;
  localparam logic [2:0] CoreExecute = 3'b101;
  localparam logic [2:0] CoreUpdate  = 3'b110;
  localparam logic [2:0] CoreDone    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_SWITCH,
    S_HOLD,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first eligible warp after cur_i, wrapping, never returning cur_i itself.
module rr_picker #(
  parameter int unsigned NUM_WARPS = 2,
  localparam int unsigned WIDX_W = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] eligible_i,
  input  logic [WIDX_W-1:0]    cur_i,
  output logic [WIDX_W-1:0]    next_o,
  output logic                 found_o
);

  always_comb begin
    int unsigned idx;
    next_o  = cur_i;
    found_o = 1'b0;
    idx     = 0;
    // Walk farthest offset first so the nearest eligible warp is written last and wins.
    for (int k = NUM_WARPS - 1; k >= 1; k--) begin
      idx = (32'(cur_i) + 32'(k)) % NUM_WARPS;
      if (eligible_i[idx[WIDX_W-1:0]]) begin
        next_o  = idx[WIDX_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Warp scheduler: launches warps, owns warp_select, and swaps warps on UPDATE, memory stall or done.
module warp_scheduler
  import warp_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 2,
  parameter bit SWITCH_ON_UPDATE = 1'b1,
  localparam int unsigned WIDX_W = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_WARPS-1:0] warp_valid,
  input  logic [2:0]           core_state,
  input  logic [NUM_WARPS-1:0] warp_done,
  input  logic [NUM_WARPS-1:0] mem_pending,
  output logic [WIDX_W-1:0]    warp_select,
  output logic [NUM_WARPS-1:0] warp_start,
  output logic                 pipe_stall,
  output logic                 busy,
  output logic                 all_done,
  output logic [7:0]           switch_count
);

  sched_state_t state_q, state_d;

  logic [WIDX_W-1:0]    warp_select_q, warp_select_d;
  logic [NUM_WARPS-1:0] warp_start_q, warp_start_d;
  logic                 pipe_stall_q, pipe_stall_d;
  logic                 busy_q, busy_d;
  logic                 all_done_q, all_done_d;
  logic [7:0]           switch_count_q, switch_count_d;
  logic [NUM_WARPS-1:0] launched_q, launched_d;
  logic [NUM_WARPS-1:0] done_l_q, done_l_d;

  logic [NUM_WARPS-1:0] eligible;
  logic [WIDX_W-1:0]    next_idx;
  logic [WIDX_W-1:0]    lowest_valid;
  logic                 found;
  logic                 active_done;
  logic                 all_fin;
  logic                 mem_trig;
  logic                 upd_trig;
  logic                 launch_go;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      eligible[i] = launched_q[i] & ~done_l_q[i] & ~warp_done[i] & ~mem_pending[i] &
                    (WIDX_W'(i) != warp_select_q);
    end
  end

  always_comb begin
    lowest_valid = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (warp_valid[i]) lowest_valid = WIDX_W'(i);
    end
  end

  rr_picker #(
    .NUM_WARPS (NUM_WARPS)
  ) u_rr_picker (
    .eligible_i (eligible),
    .cur_i      (warp_select_q),
    .next_o     (next_idx),
    .found_o    (found)
  );

  assign active_done = warp_done[warp_select_q];
  assign all_fin     = &(~launched_q | done_l_q | warp_done);
  assign mem_trig    = (core_state == CoreWait) & mem_pending[warp_select_q] & found;
  assign upd_trig    = SWITCH_ON_UPDATE & (core_state == CoreUpdate) & found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (|warp_valid) ? S_LAUNCH : S_DONE;
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        // Done of the active warp outranks any stall or update trigger.
        if (active_done) begin
          if (found)        state_d = S_SWITCH;
          else if (all_fin) state_d = S_DONE;
          else              state_d = S_HOLD;
        end else if (mem_trig || upd_trig) begin
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: state_d = S_RUN;
      S_HOLD: begin
        if (found)        state_d = S_SWITCH;
        else if (all_fin) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign launch_go = (state_q inside {S_IDLE, S_DONE}) && (state_d == S_LAUNCH);

  always_comb begin
    warp_select_d  = warp_select_q;
    warp_start_d   = '0;
    switch_count_d = switch_count_q;
    launched_d     = launched_q;
    done_l_d       = done_l_q | warp_done;
    pipe_stall_d   = (state_d == S_SWITCH) || (state_d == S_HOLD);
    busy_d         = state_d inside {S_LAUNCH, S_RUN, S_SWITCH, S_HOLD};
    all_done_d     = (state_d == S_DONE);

    if (launch_go) begin
      warp_start_d   = warp_valid;
      warp_select_d  = lowest_valid;
      switch_count_d = '0;
      launched_d     = warp_valid;
      done_l_d       = '0;
    end else if ((state_q inside {S_IDLE, S_DONE}) && start) begin
      launched_d = '0;
    end

    if (state_d == S_SWITCH) begin
      warp_select_d = next_idx;
      if (switch_count_q != 8'hFF) switch_count_d = switch_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warp_select_q  <= '0;
      warp_start_q   <= '0;
      pipe_stall_q   <= 1'b0;
      busy_q         <= 1'b0;
      all_done_q     <= 1'b0;
      switch_count_q <= '0;
      launched_q     <= '0;
      done_l_q       <= '0;
    end else begin
      warp_select_q  <= warp_select_d;
      warp_start_q   <= warp_start_d;
      pipe_stall_q   <= pipe_stall_d;
      busy_q         <= busy_d;
      all_done_q     <= all_done_d;
      switch_count_q <= switch_count_d;
      launched_q     <= launched_d;
      done_l_q       <= done_l_d;
    end
  end

  assign warp_select  = warp_select_q;
  assign warp_start   = warp_start_q;
  assign pipe_stall   = pipe_stall_q;
  assign busy         = busy_q;
  assign all_done     = all_done_q;
  assign switch_count = switch_count_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: directed scenarios plus randomized swaps against a behavioural model.
module tb_warp_scheduler;

  localparam int NW = 2;

  localparam logic [2:0] CsFetch   = 3'b001;
  localparam logic [2:0] CsWait    = 3'b100;
  localparam logic [2:0] CsExecute = 3'b101;
  localparam logic [2:0] CsUpdate  = 3'b110;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [NW-1:0] warp_valid;
  logic [2:0]    core_state;
  logic [NW-1:0] warp_done;
  logic [NW-1:0] mem_pending;
  logic          warp_select;
  logic [NW-1:0] warp_start;
  logic          pipe_stall;
  logic          busy;
  logic          all_done;
  logic [7:0]    switch_count;

  int vectors = 0;
  int miscompares = 0;

  warp_scheduler #(
    .NUM_WARPS        (NW),
    .SWITCH_ON_UPDATE (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .warp_valid   (warp_valid),
    .core_state   (core_state),
    .warp_done    (warp_done),
    .mem_pending  (mem_pending),
    .warp_select  (warp_select),
    .warp_start   (warp_start),
    .pipe_stall   (pipe_stall),
    .busy         (busy),
    .all_done     (all_done),
    .switch_count (switch_count)
  );

  wire [13:0] outs = {warp_select, warp_start, pipe_stall, busy, all_done, switch_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {select, start, stall, busy, all_done, count}
  function automatic logic [13:0] pk(int sel, logic [1:0] st, logic stall, logic bz, logic ad,
                                     int cnt);
    logic [7:0] c;
    c = (cnt > 255) ? 8'd255 : 8'(cnt);
    return {sel[0], st, stall, bz, ad, c};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    reset_n = 1'b1; start = 1'b0; warp_valid = '0; core_state = CsFetch;
    warp_done = '0; mem_pending = '0;
    #2 reset_n = 1'b0;
    tick();
    exp = pk(0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", outs, exp);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_launch();
    logic [13:0] exp;
    warp_valid = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    exp = pk(0, 2'b11, 0, 1, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL launch: got %h want %h", outs, exp);
    end
    tick();
    exp = pk(0, 2'b00, 0, 1, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL launch_run: got %h want %h", outs, exp);
    end
  endtask

  task automatic test_update_swap();
    logic [13:0] exp;
    for (int n = 1; n <= 2; n++) begin
      core_state = CsUpdate;
      tick();
      core_state = CsFetch;
      exp = pk(n % 2, 2'b00, 1, 1, 0, n);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL update_swap%0d: got %h want %h", n, outs, exp);
      end
      tick();
      exp = pk(n % 2, 2'b00, 0, 1, 0, n);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL update_resume%0d: got %h want %h", n, outs, exp);
      end
    end
  endtask

  task automatic test_mem_stall();
    logic [13:0] exp;
    core_state = CsWait; mem_pending = 2'b01;
    tick();
    core_state = CsFetch; mem_pending = 2'b00;
    exp = pk(1, 2'b00, 1, 1, 0, 3);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL mem_swap: got %h want %h", outs, exp);
    end
    tick();
    core_state = CsWait; mem_pending = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = pk(1, 2'b00, 0, 1, 0, 3);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL mem_noswap%0d: got %h want %h", i, outs, exp);
      end
    end
    core_state = CsUpdate; mem_pending = 2'b00;
    tick();
    core_state = CsFetch;
    tick();
  endtask

  task automatic test_done_path();
    logic [13:0] exp;
    warp_done = 2'b01; mem_pending = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = pk(0, 2'b00, 1, 1, 0, 4);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL hold%0d: got %h want %h", i, outs, exp);
      end
    end
    mem_pending = 2'b00;
    tick();
    exp = pk(1, 2'b00, 1, 1, 0, 5);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL hold_release: got %h want %h", outs, exp);
    end
    tick();
    warp_done = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = pk(1, 2'b00, 0, 0, 1, 5);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL all_done%0d: got %h want %h", i, outs, exp);
      end
    end
    warp_done = 2'b00;
  endtask

  task automatic test_single_warp();
    logic [13:0] exp;
    warp_valid = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    exp = pk(1, 2'b10, 0, 1, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL single_launch: got %h want %h", outs, exp);
    end
    tick();
    core_state = CsUpdate;
    tick();
    core_state = CsFetch;
    exp = pk(1, 2'b00, 0, 1, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL single_noswap: got %h want %h", outs, exp);
    end
    warp_done = 2'b10;
    tick();
    warp_done = 2'b00;
    exp = pk(1, 2'b00, 0, 0, 1, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL single_done: got %h want %h", outs, exp);
    end
  endtask

  // Model: active warp and count advance by the swap rules, computed with modular arithmetic.
  task automatic test_random();
    logic [13:0] exp;
    int active, count, next, found;
    logic [2:0] cs;
    logic [NW-1:0] mp;
    logic swap;
    warp_valid = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    active = 0; count = 0;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(2))
        0: cs = CsExecute;
        1: cs = CsWait;
        default: cs = CsUpdate;
      endcase
      mp = NW'($urandom_range(3));
      found = 0; next = active;
      for (int k = 1; k < NW; k++) begin
        if (!found && !mp[(active + k) % NW]) begin
          found = 1;
          next = (active + k) % NW;
        end
      end
      swap = found != 0 && ((cs == CsWait && mp[active]) || cs == CsUpdate);
      if (swap) begin
        active = next;
        count++;
      end
      core_state = cs; mem_pending = mp;
      tick();
      core_state = CsFetch; mem_pending = '0;
      exp = pk(active, 2'b00, swap, 1, 0, count);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL random%0d cs=%b mp=%b: got %h want %h", it, cs, mp, outs, exp);
      end
      tick();
    end
    warp_done = 2'b11;
    tick();
    warp_done = 2'b00;
  endtask

  task automatic test_saturate();
    logic [13:0] exp;
    warp_valid = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    core_state = CsUpdate;
    for (int t = 1; t <= 599; t++) begin
      tick();
      if (t == 19 || t == 599) begin
        exp = pk(((t + 1) / 2) % 2, 2'b00, 1, 1, 0, (t + 1) / 2);
        vectors++;
        if (outs !== exp) begin
          miscompares++;
          $display("FAIL saturate_t%0d: got %h want %h", t, outs, exp);
        end
      end
    end
    core_state = CsFetch;
  endtask

  task automatic test_async_reset();
    logic [13:0] exp;
    // Entered mid-SWITCH from the saturation run.
    #2 reset_n = 1'b0;
    #1;
    exp = pk(0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", outs, exp);
    end
    tick();
    reset_n = 1'b1;
    warp_valid = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    exp = pk(0, 2'b11, 0, 1, 0, 0);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL relaunch: got %h want %h", outs, exp);
    end
  endtask

  task automatic test_empty_start();
    logic [13:0] exp;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    warp_valid = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp = pk(0, 2'b00, 0, 0, 1, 0);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL empty_start%0d: got %h want %h", i, outs, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_update_swap();
    test_mem_stall();
    test_done_path();
    test_single_warp();
    test_random();
    test_saturate();
    test_async_reset();
    test_empty_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
